// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: channel FSM state encoding and default debounce time.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_HELD         = 2'b10,
    ST_RELEASE_WAIT = 2'b11
  } btn_state_e;

  // 10 ms of stable input at 100 MHz.
  localparam int unsigned DB_CYCLES_DEFAULT = 1_000_000;

  function automatic logic state_is_high(input btn_state_e st);
    return (st == ST_HELD) || (st == ST_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop sync, stable-time counter, 4-state FSM and press/release pulses.
// Raw edge to level/pulse is 2 + DB_CYCLES + 1 cycles; no flow control, pulses last one cycle.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned     CNT_W    = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             s;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], raw_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign s = sync_q[1];

  // Every exit from a WAIT state clears the counter, so it never exceeds CNT_LAST.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (s) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o   = state_is_high(state_q);
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// NUM_BTN independent debounced buttons with level, press/release pulses and, under BTN_TOGGLE_EN,
// a press-toggle latch. Raw edge to output is 2 + DB_CYCLES + 1 x1 cycles; no backpressure.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int          NUM_BTN   = 2,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic               x1,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_toggle
);

  // btn_level[0] drives the LED counter stop input, btn_level[1] the SSD mode select.
  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES (DB_CYCLES)
    ) u_ch (
      .clk_i     (x1),
      .rst_ni    (rst_n),
      .raw_i     (btn_raw[gi]),
      .level_o   (btn_level[gi]),
      .press_o   (btn_press[gi]),
      .release_o (btn_release[gi])
    );
  end

`ifdef BTN_TOGGLE_EN
  logic [NUM_BTN-1:0] toggle_q, toggle_d;

  assign toggle_d = toggle_q ^ btn_press;

  always_ff @(posedge x1 or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign btn_toggle = toggle_q;
`else
  assign btn_toggle = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with DB_CYCLES=16: vector table plus hand sequences,
// pulses checked against a scoreboard of expected events.
module tb_button_conditioner;

  localparam int NB  = 2;
  localparam int DB  = 16;
  localparam int LAT = 2 + DB + 1;
`ifdef BTN_TOGGLE_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  logic          x1      = 1'b0;
  logic          rst_n   = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_toggle;

  button_conditioner #(
    .NUM_BTN   (NB),
    .DB_CYCLES (DB)
  ) dut (
    .x1          (x1),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_toggle  (btn_toggle)
  );

  always #5 x1 = ~x1;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;
  always @(posedge x1) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
  } ev_t;

  ev_t        sb[$];
  logic [1:0] lvl_m = '0;
  logic [1:0] tog_m = '0;
  int         run_m[NB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A new raw value held for DB+1 consecutive cycles flips the debounced level LAT cycles after
  // its first cycle, i.e. 3 cycles after the last qualifying one.
  task automatic model_step(input logic [1:0] raw);
    ev_t e;
    e.cyc   = cyc + 3;
    e.press = '0;
    e.rel   = '0;
    for (int i = 0; i < NB; i++) begin
      if (raw[i] !== lvl_m[i]) run_m[i]++;
      else run_m[i] = 0;
      if (run_m[i] == DB + 1) begin
        lvl_m[i] = raw[i];
        run_m[i] = 0;
        if (raw[i]) e.press[i] = 1'b1;
        else e.rel[i] = 1'b1;
      end
    end
    if (e.press != 0 || e.rel != 0) sb.push_back(e);
  endtask

  task automatic drive(input logic [1:0] raw, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge x1);
      #1;
      btn_raw = raw;
      model_step(raw);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    lvl_m = '0;
    tog_m = '0;
    for (int i = 0; i < NB; i++) run_m[i] = 0;
  endtask

  // Called just after a rising edge; asserts reset mid-cycle and checks the async clear.
  task automatic do_reset(input int n);
    #1 rst_n = 1'b0;
    #1;
    check("rst_level", 32'(btn_level), 32'(0));
    check("rst_press", 32'(btn_press), 32'(0));
    check("rst_release", 32'(btn_release), 32'(0));
    check("rst_toggle", 32'(btn_toggle), 32'(0));
    model_clear();
    repeat (n) @(posedge x1);
    #1 rst_n = 1'b1;
    model_step(btn_raw);
  endtask

  always @(negedge x1) begin : monitor
    ev_t        e;
    logic [1:0] ep, er;
    if (rst_n) begin
      ep = '0;
      er = '0;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        total++;
        bad++;
        $display("FAIL pulse_missing: expected press=%b release=%b at cycle %0d",
                 e.press, e.rel, e.cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e  = sb.pop_front();
        ep = e.press;
        er = e.rel;
      end
      if (btn_press != 0 || btn_release != 0 || ep != 0 || er != 0) begin
        check("pulse_press", 32'(btn_press), 32'(ep));
        check("pulse_release", 32'(btn_release), 32'(er));
      end
      tog_m = tog_m ^ ep;
    end
  end

  typedef struct {
    logic [1:0] raw;
    int         len;
    logic [1:0] lvl;
  } vec_t;

  initial begin
    vec_t       tbl[12];
    logic [2:0] tog_exp;

    tbl[0]  = '{2'b00, 25, 2'b00};
    tbl[1]  = '{2'b11, 30, 2'b11};  // both pressed in the same cycle
    tbl[2]  = '{2'b10, 30, 2'b10};
    tbl[3]  = '{2'b01, 30, 2'b01};  // ch0 press and ch1 release together
    tbl[4]  = '{2'b00, 30, 2'b00};
    tbl[5]  = '{2'b01, 10, 2'b00};
    tbl[6]  = '{2'b00, 30, 2'b00};
    tbl[7]  = '{2'b01, 16, 2'b00};  // one cycle short of qualifying
    tbl[8]  = '{2'b00, 30, 2'b00};
    tbl[9]  = '{2'b01, 17, 2'b00};  // exactly qualifies, level not up yet
    tbl[10] = '{2'b00,  3, 2'b01};
    tbl[11] = '{2'b00, 30, 2'b00};
    tog_exp = TOG_EN ? 3'b101 : 3'b000;
    model_clear();

    #1 rst_n = 1'b0;
    #2;
    check("reset_level", 32'(btn_level), 32'(0));
    check("reset_pulses", 32'({btn_press, btn_release}), 32'(0));
    check("reset_toggle", 32'(btn_toggle), 32'(0));
    repeat (2) @(posedge x1);
    #1 rst_n = 1'b1;
    model_step(btn_raw);

    foreach (tbl[i]) begin
      drive(tbl[i].raw, tbl[i].len);
      check($sformatf("vec%0d_level", i), 32'(btn_level), 32'(tbl[i].lvl));
      check($sformatf("vec%0d_toggle", i), 32'(btn_toggle), 32'(TOG_EN ? tog_m : 2'b00));
    end

    // Clean ch0 press held 40 cycles.
    drive(2'b01, 1);
    drive(2'b01, LAT - 1);
    check("clean_level_early", 32'(btn_level[0]), 32'(0));
    drive(2'b01, 1);
    check("clean_level_rise", 32'(btn_level[0]), 32'(1));
    check("clean_press", 32'(btn_press), 32'(2'b01));
    drive(2'b01, 1);
    check("clean_press_width", 32'(btn_press), 32'(0));
    drive(2'b01, 19);
    drive(2'b00, 25);

    // Ch1 bounce every 5 cycles for 60 cycles, then stable high.
    for (int k = 0; k < 12; k++) drive((k % 2 == 0) ? 2'b10 : 2'b00, 5);
    drive(2'b10, 1);
    drive(2'b10, LAT - 1);
    check("bounce_level_early", 32'(btn_level[1]), 32'(0));
    drive(2'b10, 1);
    check("bounce_level_rise", 32'(btn_level[1]), 32'(1));
    check("bounce_press", 32'(btn_press), 32'(2'b10));

    // Release with a 3-cycle glitch back high.
    drive(2'b10, 10);
    drive(2'b00, 8);
    drive(2'b10, 3);
    check("glitch_still_held", 32'(btn_level), 32'(2'b10));
    drive(2'b00, 1);
    drive(2'b00, LAT - 1);
    check("glitch_level_early", 32'(btn_level[1]), 32'(1));
    drive(2'b00, 1);
    check("glitch_level_fall", 32'(btn_level[1]), 32'(0));
    check("glitch_release", 32'(btn_release), 32'(2'b10));
    drive(2'b00, 10);

    // Three ch0 presses from a clean reset.
    do_reset(2);
    for (int p = 0; p < 3; p++) begin
      drive(2'b01, 22);
      drive(2'b00, 22);
      check($sformatf("toggle_press%0d", p), 32'(btn_toggle[0]), 32'(tog_exp[p]));
    end

    // Reset at count 10 of ch0 PRESS_WAIT while ch1 is held, buttons kept down through reset.
    drive(2'b10, 25);
    drive(2'b11, 14);
    check("pre_reset_level", 32'(btn_level), 32'(2'b10));
    do_reset(3);
    drive(2'b11, LAT - 1);
    check("post_reset_level_early", 32'(btn_level), 32'(0));
    drive(2'b11, 1);
    check("post_reset_level", 32'(btn_level), 32'(2'b11));
    check("post_reset_press", 32'(btn_press), 32'(2'b11));
    drive(2'b00, 40);

    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
